// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// CPU side is a valid/ready responder; memory side is a Wishbone classic master.
module dcache_wt #(
  parameter int          NUM_LINES       = 64,
  parameter logic [3:0]  UNCACHED_NIBBLE = 4'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  input  logic        cpu_valid_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  input  logic        flush_req_i,
  output logic        flush_done_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  // Handshake: the requester holds cpu_valid_i and all request fields stable
  // until a one-cycle cpu_ready_o pulse; ready never fires without valid.
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_FLUSH, S_FLUSH_DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] flush_cnt;
  logic [TAG_W-1:0] tag;
  logic             uncached;
  logic             hit;
  logic             flush_done_q;
  logic             fill_en;
  logic             merge_en;
  logic             ready_c;
  logic [31:0]      rdata_c;
  logic             unused_addr_bits;

  assign idx              = cpu_addr_i[IDX_W+1:2];
  assign tag              = cpu_addr_i[31:IDX_W+2];
  assign uncached         = (cpu_addr_i[31:28] == UNCACHED_NIBBLE);
  assign hit              = valid_q[idx] && (tag_mem[idx] == tag) && !uncached;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    rdata_c   = 32'h0;
    fill_en   = 1'b0;
    merge_en  = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = 32'h0;
    wb_dat_o  = 32'h0;
    wb_sel_o  = 4'h0;
    case (state)
      S_IDLE: begin
        if (flush_req_i) begin
          state_nxt = S_FLUSH;
        end else if (cpu_valid_i && !cpu_we_i && hit) begin
          ready_c = 1'b1;
          rdata_c = data_mem[idx];
        end else if (cpu_valid_i && !cpu_we_i) begin
          state_nxt = S_READ;
        end else if (cpu_valid_i) begin
          state_nxt = S_WRITE;
        end
      end
      S_READ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'hF;
        wb_adr_o = {cpu_addr_i[31:2], 2'b00};
        if (wb_ack_i) begin
          ready_c   = 1'b1;
          rdata_c   = wb_dat_i;
          fill_en   = !uncached;
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_sel_o = cpu_be_i;
        wb_dat_o = cpu_wdata_i;
        wb_adr_o = {cpu_addr_i[31:2], 2'b00};
        if (wb_ack_i) begin
          ready_c   = 1'b1;
          merge_en  = hit;
          state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == IDX_W'(NUM_LINES - 1)) state_nxt = S_FLUSH_DONE;
      end
      S_FLUSH_DONE: begin
        if (!flush_req_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reset wins over any in-flight ack, so a completion never leaks out during reset.
  assign cpu_ready_o  = ready_c && rst_n && cpu_valid_i;
  assign cpu_rdata_o  = rst_n ? rdata_c : 32'h0;
  assign flush_done_o = flush_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      valid_q      <= '0;
      flush_cnt    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_done_q <= (state == S_FLUSH_DONE) && flush_req_i;
      if (state == S_IDLE) flush_cnt <= '0;
      if (state == S_FLUSH) begin
        valid_q[flush_cnt] <= 1'b0;
        flush_cnt          <= flush_cnt + 1'b1;
      end
      if (fill_en) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fill_en) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= wb_dat_i;
    end
    if (rst_n && merge_en) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_be_i[b]) data_mem[idx][8*b +: 8] <= cpu_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: a linear sequence of loads, stores, flush and reset,
// with each observation checked by an immediate assertion against hand-computed values.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush_req;
  logic        flush_done;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack;

  int errors = 0;
  int checks = 0;

  dcache_wt #(.NUM_LINES(64), .UNCACHED_NIBBLE(4'h1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_we_i     (cpu_we),
    .cpu_be_i     (cpu_be),
    .cpu_valid_i  (cpu_valid),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_ready_o  (cpu_ready),
    .flush_req_i  (flush_req),
    .flush_done_o (flush_done),
    .wb_cyc_o     (wb_cyc),
    .wb_stb_o     (wb_stb),
    .wb_we_o      (wb_we),
    .wb_adr_o     (wb_adr),
    .wb_dat_o     (wb_dat_w),
    .wb_sel_o     (wb_sel),
    .wb_dat_i     (wb_dat_r),
    .wb_ack_i     (wb_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load; on a miss the bus acks in the lat-th cycle of the Wishbone cycle.
  task automatic do_load(input logic [31:0] a, input bit exp_hit, input int lat,
                         input logic [31:0] bus_d, input logic [31:0] exp_d);
    @(negedge clk);
    cpu_addr  = a;
    cpu_we    = 1'b0;
    cpu_be    = 4'hF;
    cpu_valid = 1'b1;
    #1;
    if (exp_hit) begin
      chk("hit_ready", cpu_ready, 1);
      chk("hit_rdata", cpu_rdata, exp_d);
      chk("hit_no_cyc", wb_cyc, 0);
      @(negedge clk);
      cpu_valid = 1'b0;
    end else begin
      chk("miss_ready", cpu_ready, 0);
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        if (c == lat) begin
          wb_ack   = 1'b1;
          wb_dat_r = bus_d;
        end
        #1;
        chk("rd_cyc", wb_cyc, 1);
        chk("rd_stb", wb_stb, 1);
        chk("rd_ready", cpu_ready, (c == lat));
        if (c == 1) begin
          chk("rd_we", wb_we, 0);
          chk("rd_adr", wb_adr, a & ~32'h3);
          chk("rd_sel", wb_sel, 4'hF);
        end
        if (c == lat) chk("rd_rdata", cpu_rdata, exp_d);
      end
      @(negedge clk);
      wb_ack    = 1'b0;
      wb_dat_r  = 32'h0;
      cpu_valid = 1'b0;
      #1;
      chk("rd_end_cyc", wb_cyc, 0);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int lat);
    @(negedge clk);
    cpu_addr  = a;
    cpu_we    = 1'b1;
    cpu_be    = be;
    cpu_wdata = wd;
    cpu_valid = 1'b1;
    #1;
    chk("st_req_ready", cpu_ready, 0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == lat) wb_ack = 1'b1;
      #1;
      chk("st_cyc", wb_cyc, 1);
      chk("st_ready", cpu_ready, (c == lat));
      if (c == 1) begin
        chk("st_we", wb_we, 1);
        chk("st_adr", wb_adr, a & ~32'h3);
        chk("st_sel", wb_sel, be);
        chk("st_dat", wb_dat_w, wd);
      end
    end
    @(negedge clk);
    wb_ack    = 1'b0;
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    #1;
    chk("st_end_cyc", wb_cyc, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_we    = 1'b0;
    cpu_be    = 4'hF;
    cpu_valid = 1'b0;
    flush_req = 1'b0;
    wb_dat_r  = 32'h0;
    wb_ack    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_dat", wb_dat_w, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_flush_done", flush_done, 0);
    rst_n = 1'b1;

    // Miss then hit
    do_load(32'h8000_0010, 1'b0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load(32'h8000_0010, 1'b1, 0, 32'h0, 32'hDEAD_BEEF);

    // Store-hit byte merge
    do_store(32'h8000_0010, 4'b0100, 32'h00AA_0000, 2);
    do_load(32'h8000_0010, 1'b1, 0, 32'h0, 32'hDEAA_BEEF);

    // Conflict eviction on index 4
    do_load(32'h8000_0110, 1'b0, 1, 32'h1234_5678, 32'h1234_5678);
    do_load(32'h8000_0110, 1'b1, 0, 32'h0, 32'h1234_5678);
    do_load(32'h8000_0010, 1'b0, 2, 32'hDEAA_BEEF, 32'hDEAA_BEEF);

    // No-write-allocate, then refill of index 8
    do_store(32'h8000_0020, 4'hF, 32'h1111_1111, 1);
    do_load(32'h8000_0020, 1'b0, 1, 32'h2222_2222, 32'h2222_2222);
    do_load(32'h8000_0020, 1'b1, 0, 32'h0, 32'h2222_2222);

    // Uncached region never allocates
    do_load(32'h1000_0000, 1'b0, 1, 32'h0000_0055, 32'h0000_0055);
    do_load(32'h1000_0000, 1'b0, 2, 32'h0000_0066, 32'h0000_0066);

    // Flush with a would-be hit pending: it must be ignored until the flush ends
    @(negedge clk);
    flush_req = 1'b1;
    cpu_addr  = 32'h8000_0010;
    cpu_we    = 1'b0;
    cpu_valid = 1'b1;
    #1;
    chk("flush_req_ignores_cpu", cpu_ready, 0);
    for (int k = 0; k <= 66; k++) begin
      @(negedge clk);
      #1;
      chk("flush_done_timing", flush_done, (k >= 65));
      chk("flush_no_ready", cpu_ready, 0);
      chk("flush_no_cyc", wb_cyc, 0);
    end
    @(negedge clk);
    flush_req = 1'b0;
    cpu_valid = 1'b0;
    #1;
    chk("flush_done_held", flush_done, 1);
    @(negedge clk);
    #1;
    chk("flush_done_drop", flush_done, 0);
    do_load(32'h8000_0010, 1'b0, 1, 32'hDEAA_BEEF, 32'hDEAA_BEEF);
    do_load(32'h8000_0020, 1'b0, 1, 32'h2222_2222, 32'h2222_2222);

    // Reset mid-refill
    do_load(32'h8000_0030, 1'b0, 1, 32'h7777_7777, 32'h7777_7777);
    do_load(32'h8000_0030, 1'b1, 0, 32'h0, 32'h7777_7777);
    @(negedge clk);
    cpu_addr  = 32'h8000_0040;
    cpu_we    = 1'b0;
    cpu_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rd_cyc", wb_cyc, 1);
    rst_n  = 1'b0;
    wb_ack = 1'b1;
    #1;
    chk("rst_forces_ready_low", cpu_ready, 0);
    @(negedge clk);
    wb_ack = 1'b0;
    #1;
    chk("rst_mid_cyc", wb_cyc, 0);
    chk("rst_mid_ready", cpu_ready, 0);
    rst_n     = 1'b1;
    cpu_valid = 1'b0;
    @(negedge clk);
    wb_ack   = 1'b1;
    wb_dat_r = 32'hBAD0_BAD0;
    #1;
    chk("late_ack_cyc", wb_cyc, 0);
    chk("late_ack_ready", cpu_ready, 0);
    @(negedge clk);
    wb_ack   = 1'b0;
    wb_dat_r = 32'h0;
    do_load(32'h8000_0030, 1'b0, 1, 32'h7777_7777, 32'h7777_7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
